// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types and helpers for the parametrised dual-port RAM
package dpram_pkg;

  typedef enum logic [1:0] {READ_FIRST, WRITE_FIRST, NO_CHANGE} rdw_mode_e;

  typedef enum logic [1:0] {IDLE, CLEAR, READY} clr_state_e;

  // Widest word the byte-merge helper handles; callers zero-extend into it.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

  function automatic int dpram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Replace byte i of old_word with byte i of new_word wherever be[i] is set.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_BYTES-1:0]      be
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dpram_clear_ctrl.sv
// rtl/dpram_clear_ctrl.sv - post-reset clear sequencer that zeroes every word once
module dpram_clear_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e state;

  // Clear walks 0..DEPTH-1 one word per cycle; busy drops on the edge of the last write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR_ON_RST ? CLEAR : IDLE;
      busy     <= CLEAR_ON_RST;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= READY;
          busy  <= 1'b0;
        end
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (clr_addr == LAST_ADDR) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          busy <= 1'b0;
        end
        default: begin
          state <= READY;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Clear writes happen exactly while busy, so the strobe is the busy flop itself.
  assign clr_we = busy;

endmodule

// File: rtl/dual_port_ram_param.sv
// rtl/dual_port_ram_param.sv - parametrised true dual-port RAM with byte enables and clear
module dual_port_ram_param
  import dpram_pkg::*;
#(
  parameter int        DATA_WIDTH   = 8,
  parameter int        ADDR_WIDTH   = 6,
  parameter rdw_mode_e RDW_MODE     = READ_FIRST,
  parameter bit        OUT_REG      = 1'b0,
  parameter bit        CLEAR_ON_RST = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   data_in_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  output logic [DATA_WIDTH-1:0]   q_a,
  input  logic [DATA_WIDTH-1:0]   data_in_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    busy,
  output logic                    collision
);

  localparam int DEPTH = dpram_depth(ADDR_WIDTH);
  localparam int BYTES = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BYTES-1:0]      be
  );
    return DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_word), MAX_DATA_WIDTH'(new_word),
                                  MAX_BYTES'(be)));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  dpram_clear_ctrl #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear (
    .clock    (clock),
    .reset_n  (reset_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic                  wr_a, wr_b, same_addr;
  logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b, merged_ab;
  logic [DATA_WIDTH-1:0] rd_a, rd_b, q1_a, q1_b;

  assign wr_a      = we_a & ~busy;
  assign wr_b      = we_b & ~busy;
  assign same_addr = (addr_a == addr_b);
  assign old_a     = mem[addr_a];
  assign old_b     = mem[addr_b];
  assign merged_a  = merge(old_a, data_in_a, be_a);
  assign merged_b  = merge(old_b, data_in_b, be_b);
  // B's bytes go in first and A's on top, so A owns every byte both ports enable.
  assign merged_ab = merge(merged_b, data_in_a, be_a);

  // Array update: the clear sequencer owns port A's write path while busy; a same-address double write lands as one word.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_a && wr_b && same_addr) begin
      mem[addr_a] <= merged_ab;
    end else begin
      if (wr_a) mem[addr_a] <= merged_a;
      if (wr_b) mem[addr_b] <= merged_b;
    end
  end

  // Same-port read-during-write selection; a reader on the other port always sees the pre-write word.
  always_comb begin
    rd_a = old_a;
    rd_b = old_b;
    if (RDW_MODE == WRITE_FIRST) begin
      if (wr_a) rd_a = merged_a;
      if (wr_b) rd_b = merged_b;
    end else if (RDW_MODE == NO_CHANGE) begin
      if (wr_a) rd_a = q1_a;
      if (wr_b) rd_b = q1_b;
    end
  end

  // First read stage and collision flag; both are forced to zero for the whole clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q1_a      <= '0;
      q1_b      <= '0;
      collision <= 1'b0;
    end else if (busy) begin
      q1_a      <= '0;
      q1_b      <= '0;
      collision <= 1'b0;
    end else begin
      q1_a      <= rd_a;
      q1_b      <= rd_b;
      collision <= same_addr & (we_a | we_b);
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q2_a, q2_b;

      // Free-running output stage; it inherits zeros from stage one while busy.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q2_a <= '0;
          q2_b <= '0;
        end else begin
          q2_a <= q1_a;
          q2_b <= q1_b;
        end
      end

      assign q_a = q2_a;
      assign q_b = q2_b;
    end else begin : g_no_out_reg
      assign q_a = q1_a;
      assign q_b = q1_b;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_param.sv
// tb/tb_dual_port_ram_param.sv - scoreboard bench for dual_port_ram_param
module tb_dual_port_ram_param;
  import dpram_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] data_in_a = '0, data_in_b = '0;
  logic [5:0]  addr_a = '0, addr_b = '0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [1:0]  be_a = '0, be_b = '0;

  logic [15:0] q_a [3];
  logic [15:0] q_b [3];
  logic        busy [3];
  logic        coll [3];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          due;
    logic [15:0] val;
  } sb_t;

  sb_t sbq [9][$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  dual_port_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RDW_MODE(READ_FIRST),
                        .OUT_REG(1'b0), .CLEAR_ON_RST(1'b1)) dut_rf (
    .clock(clock), .reset_n(reset_n),
    .data_in_a(data_in_a), .addr_a(addr_a), .we_a(we_a), .be_a(be_a), .q_a(q_a[0]),
    .data_in_b(data_in_b), .addr_b(addr_b), .we_b(we_b), .be_b(be_b), .q_b(q_b[0]),
    .busy(busy[0]), .collision(coll[0]));

  dual_port_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RDW_MODE(WRITE_FIRST),
                        .OUT_REG(1'b1), .CLEAR_ON_RST(1'b1)) dut_wf (
    .clock(clock), .reset_n(reset_n),
    .data_in_a(data_in_a), .addr_a(addr_a), .we_a(we_a), .be_a(be_a), .q_a(q_a[1]),
    .data_in_b(data_in_b), .addr_b(addr_b), .we_b(we_b), .be_b(be_b), .q_b(q_b[1]),
    .busy(busy[1]), .collision(coll[1]));

  dual_port_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RDW_MODE(NO_CHANGE),
                        .OUT_REG(1'b0), .CLEAR_ON_RST(1'b1)) dut_nc (
    .clock(clock), .reset_n(reset_n),
    .data_in_a(data_in_a), .addr_a(addr_a), .we_a(we_a), .be_a(be_a), .q_a(q_a[2]),
    .data_in_b(data_in_b), .addr_b(addr_b), .we_b(we_b), .be_b(be_b), .q_b(q_b[2]),
    .busy(busy[2]), .collision(coll[2]));

  // channel = dut*3 + {0: q_a, 1: q_b, 2: collision}
  function automatic logic [15:0] obs(input int ch);
    int d, p;
    d = ch / 3;
    p = ch % 3;
    if (p == 0) return q_a[d];
    if (p == 1) return q_b[d];
    return {15'b0, coll[d]};
  endfunction

  // Monitor: pop every expectation that falls due this cycle and compare.
  always @(negedge clock) begin
    sb_t e;
    for (int ch = 0; ch < 9; ch++) begin
      while (sbq[ch].size() > 0 && sbq[ch][0].due <= cyc) begin
        e = sbq[ch].pop_front();
        total++;
        if (e.due != cyc) begin
          bad++;
          $display("FAIL sb_late ch=%0d due=%0d now=%0d", ch, e.due, cyc);
        end else if (obs(ch) !== e.val) begin
          bad++;
          $display("FAIL sb ch=%0d cyc=%0d got=%h exp=%h", ch, cyc, obs(ch), e.val);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // port: 0 q_a, 1 q_b, 2 collision; the WRITE_FIRST instance carries the extra output stage
  task automatic expq(input int d, input int port, input logic [15:0] v);
    sb_t e;
    e.due = cyc + ((d == 1 && port != 2) ? 2 : 1);
    e.val = v;
    sbq[d*3 + port].push_back(e);
  endtask

  task automatic exp_all(input int port, input logic [15:0] v);
    for (int d = 0; d < 3; d++) expq(d, port, v);
  endtask

  task automatic set_in(input logic [5:0] aa, input logic wa, input logic [1:0] ba,
                        input logic [15:0] da, input logic [5:0] ab, input logic wb,
                        input logic [1:0] bb, input logic [15:0] db);
    addr_a = aa; we_a = wa; be_a = ba; data_in_a = da;
    addr_b = ab; we_b = wb; be_b = bb; data_in_b = db;
  endtask

  task automatic drive(input logic [5:0] aa, input logic wa, input logic [1:0] ba,
                       input logic [15:0] da, input logic [5:0] ab, input logic wb,
                       input logic [1:0] bb, input logic [15:0] db);
    set_in(aa, wa, ba, da, ab, wb, bb, db);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(6'd0, 1'b0, 2'b00, 16'h0, 6'd0, 1'b0, 2'b00, 16'h0);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_qa%0d", tag, d), q_a[d], 16'h0);
      chk($sformatf("%s_qb%0d", tag, d), q_b[d], 16'h0);
      chk($sformatf("%s_coll%0d", tag, d), {15'b0, coll[d]}, 16'h0);
    end
  endtask

  // Called right after reset release; both ports hammer address 0 with writes that must be ignored.
  task automatic busy_count(input string tag);
    int cnt [3];
    cnt = '{0, 0, 0};
    set_in(6'd0, 1'b1, 2'b11, 16'hFFFF, 6'd0, 1'b1, 2'b11, 16'hFFFF);
    for (int i = 0; i < 200; i++) begin
      if (!busy[0] && !busy[1] && !busy[2]) break;
      for (int d = 0; d < 3; d++) if (busy[d]) cnt[d]++;
      if (i == 32) check_zero({tag, "_busy"});
      @(posedge clock);
      #1;
    end
    set_in(6'd0, 1'b0, 2'b00, 16'h0, 6'd0, 1'b0, 2'b00, 16'h0);
    for (int d = 0; d < 3; d++) chk($sformatf("%s_busy_len%0d", tag, d), 16'(cnt[d]), 16'd64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("rst");
    for (int d = 0; d < 3; d++) chk($sformatf("rst_busy%0d", d), {15'b0, busy[d]}, 16'h1);
    reset_n = 1'b1;
    busy_count("clr1");

    // Every word reads zero after the clear, including the address hammered while busy
    for (int i = 0; i < 64; i++) begin
      exp_all(0, 16'h0);
      exp_all(1, 16'h0);
      drive(6'(i), 1'b0, 2'b00, 16'h0, 6'(63 - i), 1'b0, 2'b00, 16'h0);
    end

    // Simultaneous writes to different addresses, then cross read
    exp_all(2, 16'h0);
    drive(6'd0, 1'b1, 2'b11, 16'h0033, 6'd1, 1'b1, 2'b11, 16'h0044);
    exp_all(0, 16'h0044);
    exp_all(1, 16'h0033);
    exp_all(2, 16'h0);
    drive(6'd1, 1'b0, 2'b00, 16'h0, 6'd0, 1'b0, 2'b00, 16'h0);

    // Same-address double write: A owns byte 0, B supplies byte 1
    exp_all(2, 16'h1);
    drive(6'd2, 1'b1, 2'b01, 16'h1155, 6'd2, 1'b1, 2'b11, 16'h7788);
    exp_all(0, 16'h7755);
    exp_all(1, 16'h0000);
    exp_all(2, 16'h0);
    drive(6'd2, 1'b0, 2'b00, 16'h0, 6'd3, 1'b0, 2'b00, 16'h0);

    // Read-during-write on port A for each mode
    drive(6'd5, 1'b1, 2'b11, 16'h0011, 6'd6, 1'b0, 2'b00, 16'h0);
    exp_all(0, 16'h7755);
    drive(6'd2, 1'b0, 2'b00, 16'h0, 6'd6, 1'b0, 2'b00, 16'h0);
    expq(0, 0, 16'h0011);
    expq(1, 0, 16'h0022);
    expq(2, 0, 16'h7755);
    drive(6'd5, 1'b1, 2'b11, 16'h0022, 6'd6, 1'b0, 2'b00, 16'h0);
    exp_all(0, 16'h0022);
    drive(6'd5, 1'b0, 2'b00, 16'h0, 6'd6, 1'b0, 2'b00, 16'h0);
    expq(0, 0, 16'h0022);
    expq(1, 0, 16'hAB22);
    expq(2, 0, 16'h0022);
    drive(6'd5, 1'b1, 2'b10, 16'hAB99, 6'd6, 1'b0, 2'b00, 16'h0);
    exp_all(0, 16'hAB22);
    drive(6'd5, 1'b0, 2'b00, 16'h0, 6'd6, 1'b0, 2'b00, 16'h0);

    // Cross-port write/read at one address: reader gets the old word
    exp_all(1, 16'h0000);
    exp_all(2, 16'h1);
    drive(6'd7, 1'b1, 2'b11, 16'h1234, 6'd7, 1'b0, 2'b00, 16'h0);
    exp_all(0, 16'h1234);
    exp_all(1, 16'h1234);
    exp_all(2, 16'h0);
    drive(6'd7, 1'b0, 2'b00, 16'h0, 6'd7, 1'b0, 2'b00, 16'h0);

    // Fill through B, then stream back-to-back reads with A wrapping 63 -> 0
    for (int i = 0; i < 64; i++)
      drive(6'd0, 1'b0, 2'b00, 16'h0, 6'(i), 1'b1, 2'b11, 16'hC000 + 16'(i));
    for (int i = 0; i < 64; i++) begin
      exp_all(0, 16'hC000 + 16'((i + 32) % 64));
      exp_all(1, 16'hC000 + 16'(63 - i));
      drive(6'((i + 32) % 64), 1'b0, 2'b00, 16'h0, 6'(63 - i), 1'b0, 2'b00, 16'h0);
    end
    idle(3);

    // Asynchronous reset clears live outputs immediately
    drive(6'd5, 1'b1, 2'b11, 16'h0055, 6'd5, 1'b0, 2'b00, 16'h0);
    for (int d = 0; d < 3; d++) chk($sformatf("pre_coll%0d", d), {15'b0, coll[d]}, 16'h1);
    chk("pre_qb0", q_b[0], 16'hC005);
    #2 reset_n = 1'b0;
    #1;
    check_zero("async");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (30) begin
      @(posedge clock);
      #1;
    end
    // Reset again mid-clear; the clear must restart from address 0
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("mid_busy%0d", d), {15'b0, busy[d]}, 16'h1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    busy_count("clr2");
    exp_all(0, 16'h0);
    exp_all(1, 16'h0);
    drive(6'd40, 1'b0, 2'b00, 16'h0, 6'd10, 1'b0, 2'b00, 16'h0);
    exp_all(0, 16'h0);
    exp_all(1, 16'h0);
    drive(6'd5, 1'b0, 2'b00, 16'h0, 6'd63, 1'b0, 2'b00, 16'h0);
    idle(4);

    for (int ch = 0; ch < 9; ch++) chk($sformatf("sb_left%0d", ch), 16'(sbq[ch].size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
